// File: rtl/ysyx_23060208_rd_arbiter.sv
// Two-master (IFU=m0, LSU=m1) round-robin read arbiter in front of the shared SRAM read port.
// One transaction in flight; grant is chosen in IDLE and held until the R handshake completes.
module ysyx_23060208_rd_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] m0_araddr,
   input  logic                  m0_arvalid,
   output logic                  m0_arready,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic [1:0]            m0_rresp,
   output logic                  m0_rvalid,
   input  logic                  m0_rready,
   input  logic [ADDR_WIDTH-1:0] m1_araddr,
   input  logic                  m1_arvalid,
   output logic                  m1_arready,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [1:0]            m1_rresp,
   output logic                  m1_rvalid,
   input  logic                  m1_rready,
   output logic [ADDR_WIDTH-1:0] s_araddr,
   output logic                  s_arvalid,
   input  logic                  s_arready,
   input  logic [DATA_WIDTH-1:0] s_rdata,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   output logic                  busy,
   output logic                  grant
);

   // Handshake rule on every channel: a transfer happens on a rising clk edge
   // where valid && ready; valid, once raised, holds with stable payload until then.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  last_grant;
   logic                  grant_q;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic                  req;
   logic                  win;
   logic                  r_ready_sel;

   // Tie goes to the master that did not win last time.
   always_comb begin
      req = (m0_arvalid || m1_arvalid) && !rst;
      if (m0_arvalid && m1_arvalid) win = ~last_grant;
      else                          win = m1_arvalid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         araddr_q   <= '0;
         grant_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && req) begin
            araddr_q   <= win ? m1_araddr : m0_araddr;
            grant_q    <= win;
            last_grant <= win;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      m0_arready  = 1'b0;
      m1_arready  = 1'b0;
      m0_rvalid   = 1'b0;
      m1_rvalid   = 1'b0;
      m0_rdata    = '0;
      m1_rdata    = '0;
      m0_rresp    = 2'b00;
      m1_rresp    = 2'b00;
      s_arvalid   = 1'b0;
      s_araddr    = araddr_q;
      r_ready_sel = grant_q ? m1_rready : m0_rready;
      s_rready    = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               m0_arready = ~win;
               m1_arready = win;
               state_nxt  = ADDR;
            end
         end
         ADDR: begin
            s_arvalid = 1'b1;
            if (s_arready) state_nxt = DATA;
         end
         DATA: begin
            s_rready = r_ready_sel;
            if (grant_q) begin
               m1_rvalid = s_rvalid;
               m1_rdata  = s_rdata;
               m1_rresp  = s_rresp;
            end else begin
               m0_rvalid = s_rvalid;
               m0_rdata  = s_rdata;
               m0_rresp  = s_rresp;
            end
            if (s_rvalid && r_ready_sel) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy  = (state != IDLE);
   assign grant = grant_q;

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Directed bench for the read arbiter: SRAM slave model, master driver tasks,
// and a negedge monitor that pops expected grants/addresses/responses from queues.
module tb_ysyx_23060208_rd_arbiter;

   logic        clk;
   logic        rst;
   logic [31:0] m0_araddr, m1_araddr;
   logic        m0_arvalid, m1_arvalid;
   logic        m0_arready, m1_arready;
   logic [31:0] m0_rdata, m1_rdata;
   logic [1:0]  m0_rresp, m1_rresp;
   logic        m0_rvalid, m1_rvalid;
   logic        m0_rready, m1_rready;
   logic [31:0] s_araddr;
   logic        s_arvalid, s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid, s_rready;
   logic        busy, grant;

   ysyx_23060208_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .busy(busy), .grant(grant)
   );

   int checks = 0;
   int errors = 0;

   logic        exp_g_q[$];
   logic [31:0] exp_a_q[$];
   logic [34:0] exp_r_q[$];
   logic [33:0] sl_q[$];
   int          ar_delay = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      tick;
      tick;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      check("rst_s_arvalid", s_arvalid, 0);
      check("rst_s_rready", s_rready, 0);
      check("rst_arready", {m0_arready, m1_arready}, 0);
      check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
      check("rst_rdata", {m0_rdata, m1_rdata}, 0);
      check("rst_rresp", {m0_rresp, m1_rresp}, 0);
      tick;
      rst = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_req(input int m, input logic [31:0] a, output int waited);
      waited = 0;
      if (m == 0) begin m0_arvalid = 1'b1; m0_araddr = a; end
      else        begin m1_arvalid = 1'b1; m1_araddr = a; end
      forever begin
         @(negedge clk);
         if ((m == 0) ? m0_arready : m1_arready) break;
         waited++;
         if (waited > 200) begin
            check("req_timeout", 1, 0);
            break;
         end
      end
      tick;
      if (m == 0) m0_arvalid = 1'b0;
      else        m1_arvalid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(name, busy, 0);
      tick;
   endtask

   task automatic expect_txn(input logic m, input logic [31:0] a, input logic [1:0] resp,
                             input logic [31:0] data);
      exp_g_q.push_back(m);
      exp_a_q.push_back(a);
      sl_q.push_back({resp, data});
      exp_r_q.push_back({m, resp, data});
   endtask

   // ---------------- SRAM slave model ----------------
   initial begin : slave
      logic smp_rst, smp_av, ar_hs, r_hs, sl_busy;
      logic [33:0] item;
      int ar_cnt;
      s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
      sl_busy = 1'b0; ar_cnt = 0;
      forever begin
         @(negedge clk);
         smp_rst = rst;
         smp_av  = s_arvalid;
         ar_hs   = s_arvalid && s_arready;
         r_hs    = s_rvalid && s_rready;
         tick;
         if (smp_rst) begin
            sl_busy = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
            ar_cnt = ar_delay; s_arready = (ar_delay == 0);
         end else if (!sl_busy) begin
            if (ar_hs) begin
               s_arready = 1'b0;
               sl_busy   = 1'b1;
               item      = (sl_q.size() > 0) ? sl_q.pop_front() : {2'b00, 32'hdeadbeef};
               s_rvalid  = 1'b1;
               s_rresp   = item[33:32];
               s_rdata   = item[31:0];
            end else if (smp_av) begin
               if (ar_cnt > 0) ar_cnt--;
               s_arready = (ar_cnt == 0);
            end else begin
               ar_cnt = ar_delay;
               s_arready = (ar_delay == 0);
            end
         end else if (r_hs) begin
            sl_busy = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
            ar_cnt = ar_delay; s_arready = (ar_delay == 0);
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic cur_m = 1'b0;
   always @(negedge clk) begin : monitor
      logic        m;
      logic [34:0] e;
      if (!rst) begin
         if (m0_arready || m1_arready) begin
            check("arready_onehot", m0_arready && m1_arready, 0);
            check("arready_when_idle", busy, 0);
            if (exp_g_q.size() == 0) check("grant_unexpected", 1, 0);
            else check("grant_master", m1_arready, exp_g_q.pop_front());
            cur_m = m1_arready;
         end
         if (s_arvalid) begin
            check("ar_busy", busy, 1);
            check("ar_grant_out", grant, cur_m);
            if (exp_a_q.size() == 0) check("ar_unexpected", 1, 0);
            else begin
               check("s_araddr", s_araddr, exp_a_q[0]);
               if (s_arready) void'(exp_a_q.pop_front());
            end
         end
         if (m0_rvalid || m1_rvalid) begin
            check("rvalid_onehot", m0_rvalid && m1_rvalid, 0);
            check("r_grant_out", grant, cur_m);
            m = m1_rvalid;
            if ((m == 0 && m0_rready) || (m == 1 && m1_rready)) begin
               check("r_s_rready", s_rready, 1);
               if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
               else begin
                  e = exp_r_q.pop_front();
                  if (m == 0) check("r_m0_resp_data", {m, m0_rresp, m0_rdata}, e);
                  else        check("r_m1_resp_data", {m, m1_rresp, m1_rdata}, e);
               end
            end else begin
               check("r_stall_s_rready", s_rready, 0);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin : stim
      int w0, w1, n;
      rst = 1'b1;
      m0_araddr = '0; m1_araddr = '0; m0_arvalid = 1'b0; m1_arvalid = 1'b0;
      m0_rready = 1'b1; m1_rready = 1'b1;
      apply_reset;

      // single IFU read, minimum latency
      expect_txn(1'b0, 32'h80000000, 2'd0, 32'h00000413);
      do_req(0, 32'h80000000, w0);
      check("t1_arready_same_cycle", w0, 0);
      @(negedge clk);
      check("t1_s_arvalid", s_arvalid, 1);
      check("t1_s_araddr", s_araddr, 32'h80000000);
      wait_idle("t1_idle");

      // simultaneous requests from reset: m0, then m1; next tie goes to m0
      apply_reset;
      expect_txn(1'b0, 32'h80000004, 2'd0, 32'h11111111);
      expect_txn(1'b1, 32'h80001000, 2'd2, 32'h22222222);
      fork
         do_req(0, 32'h80000004, w0);
         do_req(1, 32'h80001000, w1);
      join
      check("t2_m0_wait", w0, 0);
      check("t2_m1_wait", w1, 3);
      wait_idle("t2_idle");
      expect_txn(1'b0, 32'h80000008, 2'd0, 32'h33333333);
      expect_txn(1'b1, 32'h80001004, 2'd1, 32'h44444444);
      fork
         do_req(0, 32'h80000008, w0);
         do_req(1, 32'h80001004, w1);
      join
      check("t2b_m0_wait", w0, 0);
      check("t2b_m1_wait", w1, 3);
      wait_idle("t2b_idle");

      // slave stalls AR for three cycles
      ar_delay = 3;
      tick;
      expect_txn(1'b0, 32'h80000100, 2'd3, 32'h55555555);
      do_req(0, 32'h80000100, w0);
      n = 0;
      @(negedge clk);
      while (!(s_arvalid && s_arready) && n < 20) begin
         if (s_arvalid) n++;
         @(negedge clk);
      end
      check("t3_ar_stall_cycles", n, 3);
      ar_delay = 0;
      wait_idle("t3_idle");

      // LSU holds off rready for two cycles
      m1_rready = 1'b0;
      expect_txn(1'b1, 32'h80001008, 2'd0, 32'h66666666);
      do_req(1, 32'h80001008, w1);
      @(negedge clk);
      tick;
      @(negedge clk);
      check("t4_hold1_m1_rvalid", m1_rvalid, 1);
      check("t4_hold1_busy", busy, 1);
      tick;
      @(negedge clk);
      check("t4_hold2_m1_rvalid", m1_rvalid, 1);
      check("t4_hold2_s_rready", s_rready, 0);
      tick;
      m1_rready = 1'b1;
      @(negedge clk);
      check("t4_release_s_rready", s_rready, 1);
      tick;
      @(negedge clk);
      check("t4_after_busy", busy, 0);
      check("t4_after_m1_rvalid", m1_rvalid, 0);
      tick;

      // m0 arrives while m1 is in flight: granted the cycle after m1's R handshake
      expect_txn(1'b1, 32'h80001100, 2'd0, 32'h77777777);
      expect_txn(1'b0, 32'h80000300, 2'd0, 32'h88888888);
      fork
         do_req(1, 32'h80001100, w1);
         begin
            tick;
            do_req(0, 32'h80000300, w0);
         end
      join
      check("t5_m1_wait", w1, 0);
      check("t5_m0_wait", w0, 2);
      wait_idle("t5_idle");

      // reset while in DATA abandons the transaction
      m0_rready = 1'b0;
      exp_g_q.push_back(1'b0);
      exp_a_q.push_back(32'h80000400);
      sl_q.push_back({2'd0, 32'h99999999});
      do_req(0, 32'h80000400, w0);
      @(negedge clk);
      tick;
      @(negedge clk);
      check("t6_in_data_m0_rvalid", m0_rvalid, 1);
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      m0_rready = 1'b1;
      @(negedge clk);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_s_rready", s_rready, 0);
      check("t6_rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
      check("t6_rst_s_arvalid", s_arvalid, 0);
      tick;
      expect_txn(1'b0, 32'h80000404, 2'd0, 32'haaaa5555);
      do_req(0, 32'h80000404, w0);
      check("t6_after_rst_wait", w0, 0);
      wait_idle("t6_idle");

      check("end_grant_q_empty", exp_g_q.size(), 0);
      check("end_addr_q_empty", exp_a_q.size(), 0);
      check("end_resp_q_empty", exp_r_q.size(), 0);
      check("end_slave_q_empty", sl_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_23060208_rd_arbiter.md
Name: ysyx_23060208_rd_arbiter

Overview:
Two-master, one-slave read arbiter that shares the single instruction/data SRAM read port between the IFU (master 0) and the LSU (master 1). It uses the same valid/ready AR and R channel protocol as the SRAM slave. At most one transaction is outstanding at a time. Round-robin grant is decided once per transaction and held until the R handshake completes.

Parameters:
ADDR_WIDTH, 32, address width on all AR channels
DATA_WIDTH, 32, read data width on all R channels

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
m0_araddr  in  ADDR_WIDTH  IFU read address
m0_arvalid  in  1  IFU read request valid
m0_arready  out  1  IFU request accepted
m0_rdata  out  DATA_WIDTH  IFU read data
m0_rresp  out  2  IFU read response
m0_rvalid  out  1  IFU read data valid
m0_rready  in  1  IFU ready for data
m1_araddr / m1_arvalid / m1_arready / m1_rdata / m1_rresp / m1_rvalid / m1_rready  (as m0, LSU side)
s_araddr  out  ADDR_WIDTH  address to SRAM
s_arvalid  out  1  request valid to SRAM
s_arready  in  1  SRAM accepts address
s_rdata  in  DATA_WIDTH  SRAM read data
s_rresp  in  2  SRAM read response
s_rvalid  in  1  SRAM data valid
s_rready  out  1  arbiter ready for SRAM data
busy  out  1  high whenever state != IDLE
grant  out  1  master currently owning the slave (0=IFU, 1=LSU); valid when busy

Behaviour:
- States: IDLE, ADDR, DATA. Reset: state=IDLE, last_grant=1, araddr_q=0, grant_q=0.
- Outputs at reset: all *_arready, *_rvalid, s_arvalid, s_rready, busy = 0; rdata outputs = 0; rresp outputs = 0.
- Round-robin selection in IDLE:
  - only one arvalid high -> that master wins.
  - both high -> the master != last_grant wins, so m0 wins the first tie after reset.
  - neither high -> stay in IDLE.
- IDLE grant cycle, combinational:
  - mX_arready=1 for the winner only; the loser's arready=0.
  - Handshake with the winner completes in this cycle (cycle T).
  - Registered at T: araddr_q <= winner araddr; grant_q <= winner; last_grant <= winner; next state = ADDR.
- ADDR (from T+1):
  - s_arvalid=1 and s_araddr=araddr_q, held stable until s_arready.
  - On s_arvalid&&s_arready -> DATA.
  - Both mX_arready=0.
- DATA:
  - s_rready = m[grant_q]_rready.
  - m[grant_q]_rvalid = s_rvalid; m[grant_q]_rdata and _rresp = s_rdata and s_rresp (combinational pass-through).
  - Non-granted master: rvalid=0, rdata=0, rresp=0.
  - On s_rvalid&&s_rready -> IDLE.
- Minimum latency: master AR handshake at T, s_arvalid at T+1. If SRAM arready is high at T+1 and rvalid at T+2 with rready high, data completes at T+2 and the next grant can occur at T+3.
- Requests arriving while busy are not accepted. arready stays 0; the master holds arvalid per protocol. After return to IDLE the pending request is granted per the round-robin rule.
- s_arvalid is never asserted outside ADDR. s_rready is never asserted outside DATA. Stray s_rvalid in IDLE/ADDR is ignored and not forwarded.
- rresp is forwarded unmodified, including non-OKAY codes; the arbiter generates no errors.
- Reset mid-transaction returns to IDLE next cycle with all handshake outputs low. The in-flight transaction is abandoned, and the SRAM is reset by the same rst.
- grant output = grant_q; busy = (state != IDLE).

Test Plan:
- Reset, then m0_arvalid=1 with araddr=0x80000000 -> m0_arready=1 the same cycle; next cycle s_arvalid=1 with s_araddr=0x80000000. SRAM returns 0x00000413 with rresp=0 -> m0_rvalid=1, m0_rdata=0x00000413; m1_rvalid stays 0.
- Both arvalid high from reset, m0 addr 0x80000004, m1 addr 0x80001000 -> m0 granted first. Once IDLE returns, m1 is granted (s_araddr=0x80001000). A further simultaneous request grants m0 again.
- Slave holds s_arready=0 for 3 cycles in ADDR -> s_arvalid and s_araddr stay stable for all 3 cycles; no mX_arready pulses.
- m1 granted with m1_rready=0 for 2 cycles while s_rvalid=1 -> s_rready=0 and m1_rvalid=1 held, state stays DATA. When m1_rready=1, one handshake completes and the arbiter returns to IDLE.
- m0 arvalid asserted during an m1 transaction -> m0_arready stays 0 until m1's R handshake completes, then m0 is granted the following cycle.
- rst asserted while in DATA -> next cycle state=IDLE, busy=0, s_rready=0, all rvalid=0. The next request after reset is handled normally.
